xadc_drp_multichannel_sequencer: RTL and testbench

//   Reads NUM_CHANNELS XADC DRP status registers once per XADC end-of-sequence (EOS) pulse.

---
 rtl/xadc_drp_multichannel_sequencer_if.sv | 30 +++
 rtl/xadc_drp_multichannel_sequencer.sv | 154 +++++++++++++++
 tb/tb_xadc_drp_multichannel_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/xadc_drp_multichannel_sequencer_if.sv
// Shared XADC DRP types plus the tagged AXI-Stream bundle used by the sequencer.
// The stream carries one DRP result per beat, tagged with the channel index.
package xadc_drp_pkg;
  localparam int XADC_DRP_ADDR_WIDTH = 7;
  localparam int XADC_DRP_DATA_WIDTH = 16;
  typedef logic [XADC_DRP_ADDR_WIDTH-1:0] xadc_drp_addr_t;
  localparam xadc_drp_addr_t VOLTAGE_CHANNEL = 7'h10;
  localparam xadc_drp_addr_t CURRENT_CHANNEL = 7'h11;
endpackage

interface axis_interface #(
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 5,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1
);
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic [ID_WIDTH-1:0]     tid;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [USER_WIDTH-1:0]   tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tid, tdest, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tid, tdest, tuser, output tready);
  modport Source (output tvalid, tdata, tkeep, tlast, tid, tdest, tuser, input tready);
  modport Sink   (input tvalid, tdata, tkeep, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/xadc_drp_multichannel_sequencer.sv
// Reads NUM_CHANNELS XADC DRP registers per end-of-sequence pulse and streams each
// result as a tagged beat; DRP reads that never answer are aborted and flagged in tuser.
module xadc_drp_multichannel_sequencer
  import xadc_drp_pkg::*;
#(
  parameter int NUM_CHANNELS = 2,
  parameter xadc_drp_addr_t [NUM_CHANNELS-1:0] CHANNEL_ADDRS = {CURRENT_CHANNEL, VOLTAGE_CHANNEL},
  parameter int DRP_TIMEOUT_CYCLES = 64,
  parameter int COUNT_WIDTH = 16,
  parameter int TID_WIDTH = 5
) (
  input  logic                           xadc_dclk,
  input  logic                           xadc_reset,
  output xadc_drp_addr_t                 xadc_daddr,
  output logic                           xadc_den,
  input  logic                           xadc_drdy,
  input  logic [XADC_DRP_DATA_WIDTH-1:0] xadc_do,
  input  logic                           xadc_eos,
  axis_interface.Source                  sample_stream,
  output logic [COUNT_WIDTH-1:0]         overrun_count,
  output logic [COUNT_WIDTH-1:0]         timeout_count
);
  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int TMR_W = $clog2(DRP_TIMEOUT_CYCLES) + 1;
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CHANNELS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DRP_TIMEOUT_CYCLES - 1);

  if (TID_WIDTH < CH_W) begin : g_tid_width_check
    $error("TID_WIDTH too narrow for NUM_CHANNELS");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, SEND} state_t;

  state_t                         state_q, state_d;
  logic [CH_W-1:0]                ch_idx_q, ch_idx_d;
  xadc_drp_addr_t                 daddr_q, daddr_d;
  logic                           den_q, den_d;
  logic [TMR_W-1:0]               timer_q, timer_d;
  logic [XADC_DRP_DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                           tuser_q, tuser_d;
  logic                           tvalid_q, tvalid_d;
  logic [COUNT_WIDTH-1:0]         overrun_q, overrun_d;
  logic [COUNT_WIDTH-1:0]         timeout_q, timeout_d;

  logic is_last, handshake, timed_out;
  assign is_last   = (ch_idx_q == LAST_CH);
  assign handshake = tvalid_q && sample_stream.tready;
  assign timed_out = (timer_q == TMR_LAST);

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + COUNT_WIDTH'(1);
  endfunction

  always_ff @(posedge xadc_dclk or posedge xadc_reset) begin
    if (xadc_reset) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xadc_eos) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (xadc_drdy || timed_out) state_d = SEND;
      SEND:    if (handshake) state_d = is_last ? IDLE : ISSUE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ch_idx_d  = ch_idx_q;
    daddr_d   = daddr_q;
    den_d     = 1'b0;
    timer_d   = timer_q;
    tdata_d   = tdata_q;
    tuser_d   = tuser_q;
    tvalid_d  = tvalid_q;
    overrun_d = overrun_q;
    timeout_d = timeout_q;
    // An EOS that arrives mid-sequence is only counted, never queued.
    if (xadc_eos && state_q != IDLE) overrun_d = sat_inc(overrun_q);
    case (state_q)
      IDLE: begin
        if (xadc_eos) begin
          ch_idx_d = '0;
          daddr_d  = CHANNEL_ADDRS[0];
          den_d    = 1'b1;
        end
      end
      ISSUE: timer_d = TMR_W'(1);
      WAIT: begin
        if (xadc_drdy) begin
          tdata_d  = xadc_do;
          tuser_d  = 1'b0;
          tvalid_d = 1'b1;
        end else if (timed_out) begin
          tdata_d   = '0;
          tuser_d   = 1'b1;
          tvalid_d  = 1'b1;
          timeout_d = sat_inc(timeout_q);
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      SEND: begin
        if (handshake) begin
          tvalid_d = 1'b0;
          if (!is_last) begin
            ch_idx_d = ch_idx_q + CH_W'(1);
            daddr_d  = CHANNEL_ADDRS[ch_idx_q + CH_W'(1)];
            den_d    = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge xadc_dclk or posedge xadc_reset) begin
    if (xadc_reset) begin
      ch_idx_q  <= '0;
      daddr_q   <= CHANNEL_ADDRS[0];
      den_q     <= 1'b0;
      timer_q   <= '0;
      tdata_q   <= '0;
      tuser_q   <= 1'b0;
      tvalid_q  <= 1'b0;
      overrun_q <= '0;
      timeout_q <= '0;
    end else begin
      ch_idx_q  <= ch_idx_d;
      daddr_q   <= daddr_d;
      den_q     <= den_d;
      timer_q   <= timer_d;
      tdata_q   <= tdata_d;
      tuser_q   <= tuser_d;
      tvalid_q  <= tvalid_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  assign xadc_daddr           = daddr_q;
  assign xadc_den             = den_q;
  assign sample_stream.tvalid = tvalid_q;
  assign sample_stream.tdata  = tdata_q;
  assign sample_stream.tkeep  = '1;
  assign sample_stream.tlast  = is_last;
  assign sample_stream.tid    = TID_WIDTH'(ch_idx_q);
  assign sample_stream.tdest  = '0;
  assign sample_stream.tuser  = tuser_q;
  assign overrun_count        = overrun_q;
  assign timeout_count        = timeout_q;
endmodule

// File: tb/tb_xadc_drp_multichannel_sequencer.sv
// Directed bench: a two-channel instance driven from a per-beat vector table, and a
// five-channel instance with 2-bit counters for tag ordering and counter saturation.
module tb_xadc_drp_multichannel_sequencer;
  import xadc_drp_pkg::*;

  localparam int T_A = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  xadc_drp_addr_t daddr_a, daddr_b;
  logic           den_a, den_b;
  logic           drdy_a = 1'b0, drdy_b = 1'b0;
  logic [15:0]    do_a = 16'h0, do_b = 16'h0;
  logic           eos_a = 1'b0, eos_b = 1'b0;
  logic [15:0]    ovr_a, tmo_a;
  logic [1:0]     ovr_b, tmo_b;

  axis_interface #(.DATA_WIDTH(16), .ID_WIDTH(5)) axis_a ();
  axis_interface #(.DATA_WIDTH(16), .ID_WIDTH(5)) axis_b ();

  xadc_drp_multichannel_sequencer #(
    .NUM_CHANNELS(2), .DRP_TIMEOUT_CYCLES(T_A), .COUNT_WIDTH(16)
  ) u_dut_a (
    .xadc_dclk(clk), .xadc_reset(rst), .xadc_daddr(daddr_a), .xadc_den(den_a),
    .xadc_drdy(drdy_a), .xadc_do(do_a), .xadc_eos(eos_a), .sample_stream(axis_a),
    .overrun_count(ovr_a), .timeout_count(tmo_a)
  );

  xadc_drp_multichannel_sequencer #(
    .NUM_CHANNELS(5), .CHANNEL_ADDRS({7'h24, 7'h23, 7'h22, 7'h21, 7'h20}), .COUNT_WIDTH(2)
  ) u_dut_b (
    .xadc_dclk(clk), .xadc_reset(rst), .xadc_daddr(daddr_b), .xadc_den(den_b),
    .xadc_drdy(drdy_b), .xadc_do(do_b), .xadc_eos(eos_b), .sample_stream(axis_b),
    .overrun_count(ovr_b), .timeout_count(tmo_b)
  );

  typedef struct {
    int             tid;
    int             dly;       // cycles from den to drdy; -1 = never answers
    logic [15:0]    d;
    int             stall;     // cycles tready is held low after tvalid
    int             n_eos;     // eos pulses injected during the stall
    bit             eos_hs;    // eos in the handshake cycle
    xadc_drp_addr_t addr;
    logic [15:0]    exp_data;
    logic           exp_user;
    logic           exp_last;
    int             exp_ovr;
    int             exp_tmo;
  } vec_t;

  vec_t tbl[10];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in the cycle den should be high (or, for tid 0, just before the eos pulse).
  task automatic run_beat(input vec_t v);
    int k;
    bit ok;
    if (v.tid == 0) begin
      tick(); eos_a = 1'b1;
      tick(); eos_a = 1'b0;
    end
    check("den_pulse", den_a, 1'b1);
    check("den_addr", daddr_a, v.addr);
    k = 0;
    ok = 1'b1;
    while (axis_a.tvalid !== 1'b1 && k < 40) begin
      drdy_a = (k == v.dly);
      if (k == v.dly) do_a = v.d;
      tick();
      if (daddr_a !== v.addr) ok = 1'b0;
      if (k > 0 && den_a !== 1'b0) ok = 1'b0;
      k++;
    end
    drdy_a = 1'b0;
    do_a   = 16'hDEAD;
    check("wait_latency", k, (v.dly < 0) ? T_A : v.dly + 1);
    check("addr_hold_no_den", ok, 1'b1);
    check("tdata", axis_a.tdata, v.exp_data);
    check("tuser", axis_a.tuser, v.exp_user);
    check("tid", axis_a.tid, v.tid);
    check("tlast", axis_a.tlast, v.exp_last);
    check("timeout_count", tmo_a, v.exp_tmo);
    ok = 1'b1;
    for (int i = 0; i < v.stall; i++) begin
      eos_a = (i < 2 * v.n_eos) && (i % 2 == 0);
      tick();
      if (axis_a.tvalid !== 1'b1 || axis_a.tdata !== v.exp_data || axis_a.tid !== 5'(v.tid) ||
          axis_a.tlast !== v.exp_last || axis_a.tuser !== v.exp_user || den_a !== 1'b0)
        ok = 1'b0;
    end
    eos_a = 1'b0;
    if (v.stall > 0) check("stall_stable", ok, 1'b1);
    axis_a.tready = 1'b1;
    eos_a = v.eos_hs;
    tick();
    axis_a.tready = 1'b0;
    eos_a = 1'b0;
    check("tvalid_drop", axis_a.tvalid, 1'b0);
    check("den_after_hs", den_a, !v.exp_last);
    check("overrun_count", ovr_a, v.exp_ovr);
    if (v.exp_last) begin
      ok = 1'b1;
      repeat (6) begin
        tick();
        if (den_a !== 1'b0 || axis_a.tvalid !== 1'b0) ok = 1'b0;
      end
      check("no_restart", ok, 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    xadc_drp_addr_t addrs5[5];
    addrs5 = '{7'h20, 7'h21, 7'h22, 7'h23, 7'h24};
    //         tid dly  d        stall eos hs  addr             data     user  last  ovr tmo
    tbl[0] = '{0,  3,   16'h1234, 0,   0,  0, VOLTAGE_CHANNEL, 16'h1234, 1'b0, 1'b0, 0, 0};
    tbl[1] = '{1,  3,   16'h5678, 0,   0,  0, CURRENT_CHANNEL, 16'h5678, 1'b0, 1'b1, 0, 0};
    tbl[2] = '{0,  2,   16'hAAAA, 20,  0,  0, VOLTAGE_CHANNEL, 16'hAAAA, 1'b0, 1'b0, 0, 0};
    tbl[3] = '{1,  5,   16'h0F0F, 0,   0,  0, CURRENT_CHANNEL, 16'h0F0F, 1'b0, 1'b1, 0, 0};
    tbl[4] = '{0,  1,   16'h1111, 0,   0,  0, VOLTAGE_CHANNEL, 16'h1111, 1'b0, 1'b0, 0, 0};
    tbl[5] = '{1,  -1,  16'h2222, 0,   0,  0, CURRENT_CHANNEL, 16'h0000, 1'b1, 1'b1, 0, 1};
    tbl[6] = '{0,  3,   16'hBEEF, 12,  3,  0, VOLTAGE_CHANNEL, 16'hBEEF, 1'b0, 1'b0, 3, 1};
    tbl[7] = '{1,  4,   16'hCAFE, 0,   0,  0, CURRENT_CHANNEL, 16'hCAFE, 1'b0, 1'b1, 3, 1};
    tbl[8] = '{0,  7,   16'h7777, 0,   0,  0, VOLTAGE_CHANNEL, 16'h7777, 1'b0, 1'b0, 3, 1};
    tbl[9] = '{1,  -1,  16'h9999, 0,   0,  1, CURRENT_CHANNEL, 16'h0000, 1'b1, 1'b1, 4, 2};

    axis_a.tready = 1'b0;
    axis_b.tready = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_den", den_a, 1'b0);
    check("rst_daddr", daddr_a, VOLTAGE_CHANNEL);
    check("rst_tvalid", axis_a.tvalid, 1'b0);
    check("rst_tdata", axis_a.tdata, 16'h0);
    check("rst_tuser", axis_a.tuser, 1'b0);
    check("rst_tid", axis_a.tid, 5'd0);
    check("rst_tkeep", axis_a.tkeep, 2'b11);
    check("rst_tdest", axis_a.tdest, 1'b0);
    check("rst_ovr", ovr_a, 16'd0);
    check("rst_tmo", tmo_a, 16'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_beat(tbl[i]);

    // Reset while waiting on drdy.
    tick(); eos_a = 1'b1;
    tick(); eos_a = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("rstwait_den", den_a, 1'b0);
    check("rstwait_tvalid", axis_a.tvalid, 1'b0);
    check("rstwait_ovr", ovr_a, 16'd0);
    check("rstwait_tmo", tmo_a, 16'd0);
    tick(); rst = 1'b0;

    // Reset while a beat is presented.
    tick(); eos_a = 1'b1;
    tick(); eos_a = 1'b0;
    tick(); drdy_a = 1'b1; do_a = 16'h4321;
    tick(); drdy_a = 1'b0;
    check("rstsend_pre_tvalid", axis_a.tvalid, 1'b1);
    rst = 1'b1;
    #1;
    check("rstsend_tvalid", axis_a.tvalid, 1'b0);
    check("rstsend_tdata", axis_a.tdata, 16'h0);
    check("rstsend_daddr", daddr_a, VOLTAGE_CHANNEL);
    tick(); rst = 1'b0;
    run_beat(tbl[0]);
    run_beat(tbl[1]);

    // Five channels, one eos overrun per beat, 2-bit counter.
    tick(); eos_b = 1'b1;
    tick(); eos_b = 1'b0;
    for (int b = 0; b < 5; b++) begin
      check("b_den", den_b, 1'b1);
      check("b_daddr", daddr_b, addrs5[b]);
      eos_b = 1'b1;
      tick();
      eos_b = 1'b0;
      drdy_b = 1'b1;
      do_b = 16'h0100 + 16'(b);
      tick();
      drdy_b = 1'b0;
      check("b_tvalid", axis_b.tvalid, 1'b1);
      check("b_tid", axis_b.tid, b);
      check("b_tlast", axis_b.tlast, b == 4);
      check("b_tdata", axis_b.tdata, 16'h0100 + b);
      axis_b.tready = 1'b1;
      tick();
      axis_b.tready = 1'b0;
      check("b_tvalid_drop", axis_b.tvalid, 1'b0);
    end
    check("b_idle_den", den_b, 1'b0);
    check("b_overrun_sat", ovr_b, 2'd3);
    check("b_timeout", tmo_b, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
